// File: rtl/bram_frame_ctrl.sv
// bram_frame_ctrl: fills one frame of bytes into a byte-write/word-read BRAM,
// then drains it as a 32-bit word stream with valid/ready backpressure.
// The BRAM itself lives outside this block; its DO drives M_DATA directly.
module bram_frame_ctrl #(
  parameter int FRAME_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic [7:0]  S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [31:0] M_DATA,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic        M_LAST,
  output logic        FRAME_DONE,
  output logic [7:0]  BRAM_DI,
  output logic [11:0] BRAM_WRADDR,
  output logic        BRAM_WE,
  output logic        BRAM_WREN,
  output logic [9:0]  BRAM_RDADDR,
  output logic        BRAM_RDEN,
  output logic        BRAM_REGCE,
  output logic        BRAM_RST,
  input  logic [31:0] BRAM_DO
);

  localparam logic [11:0] LAST_BYTE = 12'(4 * FRAME_WORDS - 1);
  localparam logic [10:0] NUM_WORDS = 11'(FRAME_WORDS);
  localparam logic [9:0]  LAST_WORD = 10'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      r_state;
  logic [11:0] r_wr_ptr;
  logic [9:0]  r_rd_ptr;
  logic [10:0] r_rd_issued;   // reads launched in this frame, 0..FRAME_WORDS
  logic        r_s_ready;
  logic        r_m_valid;
  logic        r_m_last;
  logic        r_frame_done;

  logic        w_s_ready;
  logic        w_m_valid;
  logic        w_s_hs;
  logic        w_m_hs;
  logic        w_rden;

  // Handshake outputs are forced low while RST is held, independent of state.
  assign w_s_ready = r_s_ready & ~RST;
  assign w_m_valid = r_m_valid & ~RST;
  assign w_s_hs    = S_VALID & w_s_ready;
  assign w_m_hs    = w_m_valid & M_READY;

  // A read is launched only when the output slot is empty or being emptied,
  // so the BRAM output latch holds the presented word under backpressure.
  assign w_rden = (r_state == DRAIN) & ~RST & (r_rd_issued < NUM_WORDS)
                & (~w_m_valid | M_READY);

  // Frame sequencer: pointers, state and registered stream flags.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      r_state      <= FILL;
      r_wr_ptr     <= 12'd0;
      r_rd_ptr     <= 10'd0;
      r_rd_issued  <= 11'd0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_s_ready    <= ~RST;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FILL: begin
          r_s_ready <= 1'b1;
          if (w_s_hs) begin
            if (r_wr_ptr == LAST_BYTE) begin
              r_wr_ptr  <= 12'd0;
              r_state   <= DRAIN;
              r_s_ready <= 1'b0;
            end else begin
              r_wr_ptr <= r_wr_ptr + 12'd1;
            end
          end else begin
            r_wr_ptr <= r_wr_ptr;
          end
        end
        DRAIN: begin
          r_s_ready <= 1'b0;
          if (w_rden) begin
            r_rd_ptr    <= r_rd_ptr + 10'd1;
            r_rd_issued <= r_rd_issued + 11'd1;
            r_m_valid   <= 1'b1;
            r_m_last    <= (r_rd_ptr == LAST_WORD);
          end else if (w_m_hs) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
          end else begin
            r_m_valid <= r_m_valid;
          end
          // The last word can never coincide with a new read: all reads
          // have been issued by the time it is presented.
          if (w_m_hs && r_m_last) begin
            r_frame_done <= 1'b1;
            r_rd_ptr     <= 10'd0;
            r_rd_issued  <= 11'd0;
            r_state      <= FILL;
            r_s_ready    <= 1'b1;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state   <= FILL;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign S_READY     = w_s_ready;
  assign M_DATA      = BRAM_DO;
  assign M_VALID     = w_m_valid;
  assign M_LAST      = r_m_last & w_m_valid;
  assign FRAME_DONE  = r_frame_done & ~RST;
  assign BRAM_DI     = S_DATA;
  assign BRAM_WRADDR = r_wr_ptr;
  assign BRAM_WE     = w_s_hs;
  assign BRAM_WREN   = w_s_hs;
  assign BRAM_RDADDR = r_rd_ptr;
  assign BRAM_RDEN   = w_rden;
  assign BRAM_REGCE  = 1'b0;
  assign BRAM_RST    = RST;

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Directed bench for bram_frame_ctrl: a FRAME_WORDS=4 instance for the
// handshake scenarios and a FRAME_WORDS=1024 instance for the full frame.
// Each instance is paired with a small behavioural model of the BRAM.
module tb_bram_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- instance A (FRAME_WORDS=4) ----------------
  logic        a_rst, a_clr, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_m_last, a_frame_done;
  logic [7:0]  a_s_data, a_bram_di;
  logic [31:0] a_m_data, a_bram_do;
  logic [11:0] a_bram_wraddr;
  logic [9:0]  a_bram_rdaddr;
  logic        a_bram_we, a_bram_wren, a_bram_rden, a_bram_regce, a_bram_rst;
  logic [7:0]  a_mem [0:4095];

  bram_frame_ctrl #(.FRAME_WORDS(4)) dut_a (
    .CLK(clk), .RST(a_rst), .CLR(a_clr),
    .S_DATA(a_s_data), .S_VALID(a_s_valid), .S_READY(a_s_ready),
    .M_DATA(a_m_data), .M_VALID(a_m_valid), .M_READY(a_m_ready), .M_LAST(a_m_last),
    .FRAME_DONE(a_frame_done),
    .BRAM_DI(a_bram_di), .BRAM_WRADDR(a_bram_wraddr), .BRAM_WE(a_bram_we), .BRAM_WREN(a_bram_wren),
    .BRAM_RDADDR(a_bram_rdaddr), .BRAM_RDEN(a_bram_rden), .BRAM_REGCE(a_bram_regce),
    .BRAM_RST(a_bram_rst), .BRAM_DO(a_bram_do)
  );

  // BRAM model for A: byte writes, little-endian 32-bit reads, DO_REG=0.
  always @(posedge clk) begin
    if (a_bram_we && a_bram_wren) a_mem[a_bram_wraddr] <= a_bram_di;
    if (a_bram_rst) a_bram_do <= 32'h0;
    else if (a_bram_rden)
      a_bram_do <= {a_mem[{a_bram_rdaddr, 2'd3}], a_mem[{a_bram_rdaddr, 2'd2}],
                    a_mem[{a_bram_rdaddr, 2'd1}], a_mem[{a_bram_rdaddr, 2'd0}]};
  end

  // ---------------- instance B (FRAME_WORDS=1024) ----------------
  logic        b_rst, b_clr, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last, b_frame_done;
  logic [7:0]  b_s_data, b_bram_di;
  logic [31:0] b_m_data, b_bram_do;
  logic [11:0] b_bram_wraddr;
  logic [9:0]  b_bram_rdaddr;
  logic        b_bram_we, b_bram_wren, b_bram_rden, b_bram_regce, b_bram_rst;
  logic [7:0]  b_mem [0:4095];

  bram_frame_ctrl #(.FRAME_WORDS(1024)) dut_b (
    .CLK(clk), .RST(b_rst), .CLR(b_clr),
    .S_DATA(b_s_data), .S_VALID(b_s_valid), .S_READY(b_s_ready),
    .M_DATA(b_m_data), .M_VALID(b_m_valid), .M_READY(b_m_ready), .M_LAST(b_m_last),
    .FRAME_DONE(b_frame_done),
    .BRAM_DI(b_bram_di), .BRAM_WRADDR(b_bram_wraddr), .BRAM_WE(b_bram_we), .BRAM_WREN(b_bram_wren),
    .BRAM_RDADDR(b_bram_rdaddr), .BRAM_RDEN(b_bram_rden), .BRAM_REGCE(b_bram_regce),
    .BRAM_RST(b_bram_rst), .BRAM_DO(b_bram_do)
  );

  // BRAM model for B.
  always @(posedge clk) begin
    if (b_bram_we && b_bram_wren) b_mem[b_bram_wraddr] <= b_bram_di;
    if (b_bram_rst) b_bram_do <= 32'h0;
    else if (b_bram_rden)
      b_bram_do <= {b_mem[{b_bram_rdaddr, 2'd3}], b_mem[{b_bram_rdaddr, 2'd2}],
                    b_mem[{b_bram_rdaddr, 2'd1}], b_mem[{b_bram_rdaddr, 2'd0}]};
  end

  // ---------------- recorders for A ----------------
  logic [7:0]  a_txq[$];
  logic [31:0] a_rx[$];
  logic        a_rxl[$];
  int          a_rxc[$];
  logic [31:0] a_stall_data[$];
  int a_byte_cnt, a_addr_err, a_done_cnt, a_cyc, a_stall_left, a_stall_rden;
  logic a_sr_pending, a_sr_after_last, a_sr_at_done;

  task automatic clear_rec_a();
    a_txq.delete(); a_rx.delete(); a_rxl.delete(); a_rxc.delete(); a_stall_data.delete();
    a_byte_cnt = 0; a_addr_err = 0; a_done_cnt = 0; a_cyc = 0;
    a_stall_left = 0; a_stall_rden = 0;
    a_sr_pending = 1'b0; a_sr_after_last = 1'bx; a_sr_at_done = 1'bx;
  endtask

  task automatic load_a(input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      a_txq.push_back(b);
      b = b + 8'd1;
    end
  endtask

  // One clock of instance A: drive inputs, observe, advance to the next edge.
  task automatic cyc_a(input bit sv_en, input bit mr, input bit clr);
    a_s_valid = sv_en && (a_txq.size() != 0);
    a_s_data  = (a_txq.size() != 0) ? a_txq[0] : 8'h00;
    a_m_ready = mr;
    a_clr     = clr;
    #1;
    if (a_frame_done === 1'b1) begin a_done_cnt++; a_sr_at_done = a_s_ready; end
    if (a_sr_pending) begin a_sr_after_last = a_s_ready; a_sr_pending = 1'b0; end
    if (a_m_valid === 1'b1 && !mr) begin
      a_stall_data.push_back(a_m_data);
      if (a_bram_rden !== 1'b0) a_stall_rden++;
    end
    if (a_s_valid && a_s_ready === 1'b1) begin
      if (a_bram_wraddr !== 12'(a_byte_cnt) || a_bram_we !== 1'b1 ||
          a_bram_wren !== 1'b1 || a_bram_di !== a_s_data) a_addr_err++;
      void'(a_txq.pop_front());
      a_byte_cnt++;
      if (a_byte_cnt == 16) begin a_byte_cnt = 0; a_sr_pending = 1'b1; end
    end else if (a_bram_we !== 1'b0 || a_bram_wren !== 1'b0) begin
      a_addr_err++;
    end
    if (a_m_valid === 1'b1 && mr) begin
      a_rx.push_back(a_m_data); a_rxl.push_back(a_m_last); a_rxc.push_back(a_cyc);
    end
    if (clr) a_byte_cnt = 0;
    @(posedge clk); #1;
    a_cyc++;
  endtask

  // Run A until one frame completes (plus two idle cycles) or the budget runs out.
  // mode 0: steady; 1: stall three cycles on word 1; 2: random S_VALID.
  task automatic run_a(input int budget, input int mode);
    int n = 0, extra = 0;
    bit sv, mr;
    while (n < budget && extra < 2) begin
      sv = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      mr = 1'b1;
      if (mode == 1 && a_rx.size() == 1 && a_m_valid === 1'b1 && a_stall_left > 0) begin
        mr = 1'b0;
        a_stall_left--;
      end
      cyc_a(sv, mr, 1'b0);
      n++;
      if (a_done_cnt > 0) extra++;
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13) + (i >> 8));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (a_s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b want 0", a_s_ready); end
    vectors++; if (a_m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", a_m_valid); end
    vectors++; if ({a_bram_we, a_bram_wren, a_bram_rden} !== 3'b000) begin miscompares++; $display("FAIL reset_bram_en: got %b want 000", {a_bram_we, a_bram_wren, a_bram_rden}); end
    vectors++; if (a_bram_rst !== 1'b1 || a_bram_regce !== 1'b0) begin miscompares++; $display("FAIL reset_bram_rst_regce: got %b%b want 10", a_bram_rst, a_bram_regce); end
    vectors++; if (a_frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", a_frame_done); end
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (a_s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_s_ready: got %b want 1", a_s_ready); end
    vectors++; if (a_m_valid !== 1'b0 || a_bram_rst !== 1'b0) begin miscompares++; $display("FAIL reset_release_state: got %b%b want 00", a_m_valid, a_bram_rst); end
  endtask

  task automatic check_frame_a(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] exp [4];
    exp[0] = w0; exp[1] = w1; exp[2] = w2; exp[3] = w3;
    vectors++; if (a_rx.size() != 4) begin miscompares++; $display("FAIL %s_word_count: got %0d want 4", tag, a_rx.size()); end
    for (int i = 0; i < 4 && i < a_rx.size(); i++) begin
      vectors++; if (a_rx[i] !== exp[i]) begin miscompares++; $display("FAIL %s_word%0d: got %h want %h", tag, i, a_rx[i], exp[i]); end
      vectors++; if (a_rxl[i] !== (i == 3)) begin miscompares++; $display("FAIL %s_last%0d: got %b want %b", tag, i, a_rxl[i], (i == 3)); end
    end
    vectors++; if (a_done_cnt != 1) begin miscompares++; $display("FAIL %s_frame_done_count: got %0d want 1", tag, a_done_cnt); end
    vectors++; if (a_sr_at_done !== 1'b1) begin miscompares++; $display("FAIL %s_s_ready_after_done: got %b want 1", tag, a_sr_at_done); end
    vectors++; if (a_addr_err != 0) begin miscompares++; $display("FAIL %s_write_port: got %0d bad writes want 0", tag, a_addr_err); end
  endtask

  task automatic test_fill_drain();
    clear_rec_a(); load_a(8'h01, 16);
    run_a(80, 0);
    check_frame_a("fill_drain", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    vectors++; if (a_sr_after_last !== 1'b0) begin miscompares++; $display("FAIL fill_s_ready_drop: got %b want 0", a_sr_after_last); end
    vectors++; if (a_rxc.size() == 4 && (a_rxc[3] - a_rxc[0]) != 3) begin miscompares++; $display("FAIL drain_throughput: got %0d cycles want 3", a_rxc[3] - a_rxc[0]); end
  endtask

  task automatic test_backpressure();
    clear_rec_a(); load_a(8'h01, 16);
    a_stall_left = 3;
    run_a(80, 1);
    check_frame_a("backpressure", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    vectors++; if (a_stall_data.size() != 3) begin miscompares++; $display("FAIL stall_cycles: got %0d want 3", a_stall_data.size()); end
    foreach (a_stall_data[i]) begin
      vectors++; if (a_stall_data[i] !== 32'h08070605) begin miscompares++; $display("FAIL stall_data%0d: got %h want 08070605", i, a_stall_data[i]); end
    end
    vectors++; if (a_stall_rden != 0) begin miscompares++; $display("FAIL stall_rden: got %0d want 0", a_stall_rden); end
  endtask

  task automatic test_gappy_fill();
    clear_rec_a(); load_a(8'h01, 16);
    run_a(300, 2);
    check_frame_a("gappy_fill", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
  endtask

  task automatic test_clr();
    int n = 0;
    clear_rec_a(); load_a(8'h01, 9);
    while (a_txq.size() != 0 && n < 40) begin cyc_a(1'b1, 1'b1, 1'b0); n++; end
    a_txq.push_back(8'h55);
    cyc_a(1'b1, 1'b1, 1'b1);     // CLR together with a byte handshake
    vectors++; if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin miscompares++; $display("FAIL clr_next_cycle: got valid=%b ready=%b want 0 1", a_m_valid, a_s_ready); end
    load_a(8'hA0, 16);
    run_a(80, 0);
    check_frame_a("after_clr", 32'hA3A2A1A0, 32'hA7A6A5A4, 32'hABAAA9A8, 32'hAFAEADAC);
  endtask

  task automatic test_rst_in_drain();
    int n = 0;
    clear_rec_a(); load_a(8'h01, 16);
    while (a_rx.size() < 1 && n < 60) begin cyc_a(1'b1, 1'b1, 1'b0); n++; end
    a_rst = 1'b1;
    #1;
    vectors++; if (a_m_valid !== 1'b0 || a_s_ready !== 1'b0 || a_bram_rden !== 1'b0) begin miscompares++; $display("FAIL rst_during: got valid=%b ready=%b rden=%b want 000", a_m_valid, a_s_ready, a_bram_rden); end
    cyc_a(1'b0, 1'b1, 1'b0);
    a_rst = 1'b0;
    #1;
    vectors++; if (a_m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_after_m_valid: got %b want 0", a_m_valid); end
    cyc_a(1'b0, 1'b1, 1'b0);
    vectors++; if (a_s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_s_ready: got %b want 1", a_s_ready); end
    clear_rec_a(); load_a(8'h21, 16);
    run_a(80, 0);
    check_frame_a("after_rst", 32'h24232221, 32'h28272625, 32'h2C2B2A29, 32'h302F2E2D);
  endtask

  task automatic test_full_frame();
    int sent = 0, words = 0, word_err = 0, last_cnt = 0, last_idx = -1, wr_err = 0, n = 0;
    int max_rd = 0;
    bit done = 1'b0;
    logic [11:0] final_wr = 12'h000;
    logic [31:0] exp;
    b_m_ready = 1'b1;
    while (!done && n < 6000) begin
      b_s_valid = (sent < 4096);
      b_s_data  = pat(sent);
      #1;
      if (b_s_valid && b_s_ready === 1'b1) begin
        if (b_bram_wraddr !== 12'(sent)) wr_err++;
        if (sent == 4095) final_wr = b_bram_wraddr;
        sent++;
      end
      if (b_bram_rden === 1'b1 && int'(b_bram_rdaddr) > max_rd) max_rd = int'(b_bram_rdaddr);
      if (b_m_valid === 1'b1) begin
        exp = {pat(4 * words + 3), pat(4 * words + 2), pat(4 * words + 1), pat(4 * words)};
        if (b_m_data !== exp) begin
          if (word_err == 0) $display("FAIL full_word%0d: got %h want %h", words, b_m_data, exp);
          word_err++;
        end
        if (b_m_last === 1'b1) begin last_cnt++; last_idx = words; end
        words++;
      end
      if (b_frame_done === 1'b1) done = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    b_s_valid = 1'b0;
    vectors++; if (sent != 4096) begin miscompares++; $display("FAIL full_bytes: got %0d want 4096", sent); end
    vectors++; if (wr_err != 0 || final_wr !== 12'hFFF) begin miscompares++; $display("FAIL full_wraddr: got %0d errors last=%h want 0 fff", wr_err, final_wr); end
    vectors++; if (words != 1024) begin miscompares++; $display("FAIL full_word_count: got %0d want 1024", words); end
    vectors++; if (word_err != 0) begin miscompares++; $display("FAIL full_word_data: got %0d bad words want 0", word_err); end
    vectors++; if (last_cnt != 1 || last_idx != 1023) begin miscompares++; $display("FAIL full_last: got count=%0d idx=%0d want 1 1023", last_cnt, last_idx); end
    vectors++; if (max_rd != 1023) begin miscompares++; $display("FAIL full_rdaddr_max: got %0d want 1023", max_rd); end
    b_s_valid = 1'b1; b_s_data = 8'h77;
    #1;
    vectors++; if (b_s_ready !== 1'b1 || b_bram_wraddr !== 12'h000) begin miscompares++; $display("FAIL full_wrap: got ready=%b wraddr=%h want 1 000", b_s_ready, b_bram_wraddr); end
    @(posedge clk); #1;
    b_s_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_clr = 1'b0; a_s_valid = 1'b0; a_s_data = 8'h00; a_m_ready = 1'b0;
    b_rst = 1'b1; b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b0;
    clear_rec_a();
    @(posedge clk); #1;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_gappy_fill();
    test_clr();
    test_rst_in_drain();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
